// File: rtl/seq_det_param.sv
// seq_det_param: runtime-programmable Mealy serial-pattern detector.
// Compares the newest PAT_W accepted bits against cfg_pat under cfg_mask.
// It runs in overlapping or non-overlapping mode and has a saturating
// match counter.
// Build option: define SEQ_DET_CNT_EN to build the match counter.
// When it is undefined, match_cnt is tied to zero and no counter flops exist.
module seq_det_param #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             in,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic             cfg_ovl,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt
);

  // fill only needs to reach PAT_W-1, so clog2(PAT_W) bits suffice.
  localparam int FILL_W = (PAT_W <= 2) ? 1 : $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

  logic [PAT_W-2:0]  hist;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  win;
  logic              full;
  logic              hit;
  logic              accept;

  // The comparison window is the stored history with the live bit appended.
  // The oldest bit lands in the MSB, which lines up with cfg_pat.
  assign win    = {hist, in};
  assign full   = (fill == FILL_FULL);
  assign hit    = (((win ^ cfg_pat) & cfg_mask) == '0);
  assign accept = in_valid & ~clr;
  assign match  = rst & accept & full & hit;

  // History shift register: accepted bits enter at bit 0.
  // The window's low bits become the new history, so PAT_W=2 needs no special case.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
    end else if (clr) begin
      hist <= '0;
    end else if (in_valid) begin
      hist <= win[PAT_W-2:0];
    end
  end

  // Fill tracker: saturates at PAT_W-1 once the window is full.
  // A non-overlapping match restarts it so the next match needs PAT_W fresh bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill <= '0;
    end else if (clr) begin
      fill <= '0;
    end else if (in_valid) begin
      if (match && !cfg_ovl) begin
        fill <= '0;
      end else if (!full) begin
        fill <= fill + 1'b1;
      end
    end
  end

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt;

  // Saturating match counter: it holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (match && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign match_cnt = cnt;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// tb_seq_det_param: scoreboard bench for seq_det_param with PAT_W=4.
// It runs two instances on shared inputs, one with CNT_W=8 and one with CNT_W=2.
module tb_seq_det_param;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       in_valid;
  logic       in;
  logic [3:0] cfg_pat;
  logic [3:0] cfg_mask;
  logic       cfg_ovl;
  logic       match;
  logic [7:0] match_cnt;
  logic       match2;
  logic [1:0] match_cnt2;

  typedef struct {
    logic       m;
    logic [7:0] c8;
    logic [1:0] c2;
  } exp_t;

  exp_t sb[$];
  int   cnt_model;
  int   errors;
  int   checks;

  seq_det_param #(.PAT_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in(in),
    .cfg_pat(cfg_pat), .cfg_mask(cfg_mask), .cfg_ovl(cfg_ovl),
    .match(match), .match_cnt(match_cnt)
  );

  seq_det_param #(.PAT_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in(in),
    .cfg_pat(cfg_pat), .cfg_mask(cfg_mask), .cfg_ovl(cfg_ovl),
    .match(match2), .match_cnt(match_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected counter value for a given match total and counter width.
  function automatic int sat_cnt(input int c, input int w);
`ifdef SEQ_DET_CNT_EN
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
`else
    return 0;
`endif
  endfunction

  // Drive one cycle, then push the expectation and check match mid-phase.
  // Counters are checked just after the following rising edge.
  task automatic drive_bit(input logic v, input logic b, input logic c, input logic exp_m);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    in       = b;
    clr      = c;
    if (c) cnt_model = 0;
    else if (exp_m) cnt_model++;
    e.m  = exp_m;
    e.c8 = 8'(sat_cnt(cnt_model, 8));
    e.c2 = 2'(sat_cnt(cnt_model, 2));
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    checks++;
    if (match !== e.m) begin
      errors++;
      $display("[TB] FAIL match t=%0t got=%b exp=%b", $time, match, e.m);
    end
    checks++;
    if (match2 !== e.m) begin
      errors++;
      $display("[TB] FAIL match2 t=%0t got=%b exp=%b", $time, match2, e.m);
    end
    @(posedge clk);
    #1;
    checks++;
    if (match_cnt !== e.c8) begin
      errors++;
      $display("[TB] FAIL match_cnt t=%0t got=%0d exp=%0d", $time, match_cnt, e.c8);
    end
    checks++;
    if (match_cnt2 !== e.c2) begin
      errors++;
      $display("[TB] FAIL match_cnt2 t=%0t got=%0d exp=%0d", $time, match_cnt2, e.c2);
    end
    clr = 1'b0;
  endtask

  // Feed n valid bits (bits[0] first) with per-bit expected match flags.
  task automatic feed(input logic [15:0] bits, input logic [15:0] exps, input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1, bits[i], 1'b0, exps[i]);
  endtask

  task automatic do_clr();
    drive_bit(1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  // Hold reset low for one cycle and check that outputs are forced to zero.
  task automatic pulse_reset();
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b1;
    in        = 1'b0;
    cnt_model = 0;
    #1;
    checks++;
    if (match !== 1'b0 || match2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_match got=%b/%b exp=0", match, match2);
    end
    @(posedge clk);
    #1;
    checks++;
    if (match_cnt !== 8'd0 || match_cnt2 !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_cnt got=%0d/%0d exp=0", match_cnt, match_cnt2);
    end
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
  endtask

  task automatic test_non_overlap();
    cfg_pat = 4'b1010; cfg_mask = 4'b1111; cfg_ovl = 1'b0;
    do_clr();
    feed(16'h0055, 16'h0088, 8);
  endtask

  task automatic test_overlap();
    cfg_pat = 4'b1010; cfg_mask = 4'b1111; cfg_ovl = 1'b1;
    do_clr();
    feed(16'h0055, 16'h00A8, 8);
  endtask

  task automatic test_mask();
    cfg_pat = 4'b1010; cfg_mask = 4'b1101; cfg_ovl = 1'b1;
    do_clr();
    feed(16'h0001, 16'h0008, 4);
    cfg_mask = 4'b1111;
    do_clr();
    feed(16'h0001, 16'h0000, 4);
  endtask

  task automatic test_zero_mask();
    cfg_pat = 4'b1010; cfg_mask = 4'b0000; cfg_ovl = 1'b0;
    do_clr();
    feed(16'h003C, 16'h0088, 8);
  endtask

  task automatic test_valid_gap();
    cfg_pat = 4'b1010; cfg_mask = 4'b1111; cfg_ovl = 1'b0;
    do_clr();
    feed(16'h0005, 16'h0000, 3);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, i[0], 1'b0, 1'b0);
    drive_bit(1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_mid_reset();
    cfg_pat = 4'b1010; cfg_mask = 4'b1111; cfg_ovl = 1'b0;
    do_clr();
    feed(16'h0005, 16'h0000, 3);
    pulse_reset();
    feed(16'h000A, 16'h0010, 5);
  endtask

  task automatic test_saturate_and_clr();
    cfg_pat = 4'b1010; cfg_mask = 4'b1111; cfg_ovl = 1'b1;
    do_clr();
    feed(16'h0555, 16'h0AA8, 12);
    drive_bit(1'b1, 1'b1, 1'b0, 1'b0);
    drive_bit(1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    cnt_model = 0;
    rst       = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in        = 1'b0;
    cfg_pat   = 4'b1010;
    cfg_mask  = 4'b1111;
    cfg_ovl   = 1'b0;
    #2;
    rst = 1'b1;
    test_reset();
    test_non_overlap();
    test_overlap();
    test_mask();
    test_zero_mask();
    test_valid_gap();
    test_mid_reset();
    test_saturate_and_clr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
